// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider among NREQ requesters.
// Captures the winner's operands, starts the divider and returns quotient with done/err.
//
// state | meaning
// IDLE  | waiting for any req; grants the round-robin winner and latches operands
// CHECK | rejects a zero divisor without starting the divider
// ISSUE | pulses div_start and clears the timer
// WAIT  | waits for div_valid or timer == TIMEOUT
// RESP  | pulses done/err to the owner, advances the round-robin pointer
module div_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dividend_in,
    input  logic [NREQ*WIDTH-1:0] divisor_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic [WIDTH-1:0]      q_out,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic                  div_valid,
    input  logic [WIDTH-1:0]      div_q
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   timer;
    logic            err_flag;
    logic [WIDTH-1:0] q_cap;

    logic [WIDTH-1:0] dvd [NREQ];
    logic [WIDTH-1:0] dvs [NREQ];
    logic [IW-1:0]    winner;
    logic             found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dvd[i] = dividend_in[i*WIDTH +: WIDTH];
            dvs[i] = divisor_in[i*WIDTH +: WIDTH];
        end
    end

    // First set request scanning upward from rr_ptr with wrap-around.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] pos;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            idx       <= '0;
            timer     <= '0;
            err_flag  <= 1'b0;
            q_cap     <= '0;
            q_out     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_start <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
        end else begin
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt[winner] <= 1'b1;
                        idx         <= winner;
                        div_a       <= dvd[winner];
                        div_b       <= dvs[winner];
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (div_b == '0) begin
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_start <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A valid in the timeout cycle still counts as success.
                    if (div_valid) begin
                        q_cap    <= div_q;
                        err_flag <= 1'b0;
                        state    <= RESP;
                    end else if (timer == TW'(TIMEOUT)) begin
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    done[idx] <= 1'b1;
                    err[idx]  <= err_flag;
                    if (!err_flag) begin
                        q_out <= q_cap;
                    end
                    if (idx == IW'(NREQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= idx + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed table, hand-written corner sequences and random jobs
// checked against a behavioural model of arbitration order, latency and quotient.
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 10;
    localparam int TO   = 63;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   dividend_in;
    logic [NREQ*W-1:0]   divisor_in;
    logic [NREQ-1:0]     gnt, done, err;
    logic [W-1:0]        q_out;
    logic                div_start;
    logic [W-1:0]        div_a, div_b;
    logic                div_valid;
    logic [W-1:0]        div_q;

    div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .gnt(gnt), .done(done), .err(err), .q_out(q_out),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_valid(div_valid), .div_q(div_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    typedef struct { int idx; int cyc; int e; int q; } ev_t;
    typedef struct { int cyc; int a; int b; } st_t;
    ev_t gq[$];
    ev_t dq[$];
    st_t sq[$];
    int  last_order[$];
    int  mp = 0;      // model round-robin pointer
    int  dv_lat = 0;  // divider model latency in cycles after div_start, -1 = never
    bit  dv_en = 1'b1;

    function automatic int oh2i(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot_excl", int'($onehot0(gnt) && $onehot0(done) && ((err & ~done) == '0)), 1);
            if (gnt != '0) gq.push_back('{oh2i(gnt), cyc, 0, 0});
            if (done != '0) dq.push_back('{oh2i(done), cyc, int'(err != '0), int'(q_out)});
            if (div_start) sq.push_back('{cyc, int'(div_a), int'(div_b)});
        end
    end

    // Requesters hold req until granted.
    initial begin
        forever begin
            @(negedge clk);
            req = req & ~gnt;
        end
    end

    // Behavioural divider: answers a/b dv_lat cycles after seeing div_start.
    initial begin
        int sa, sb, l;
        div_valid = 1'b0;
        div_q     = '0;
        forever begin
            @(negedge clk);
            if (div_start && dv_en && rst_n) begin
                l  = dv_lat;
                sa = int'(div_a);
                sb = int'(div_b);
                if (l >= 0) begin
                    repeat (l) @(negedge clk);
                    div_q     = (sb != 0) ? W'(sa / sb) : '1;
                    div_valid = 1'b1;
                    @(negedge clk);
                    div_valid = 1'b0;
                end
            end
        end
    end

    task automatic clear_q();
        gq.delete(); dq.delete(); sq.delete();
    endtask

    task automatic run_job(int r, int a, int b, int lat, int eq, int ee, int el);
        int n;
        clear_q();
        dv_lat = lat;
        @(negedge clk); #1;
        dividend_in[r*W +: W] = W'(a);
        divisor_in[r*W +: W]  = W'(b);
        req[r] = 1'b1;
        n = 0;
        while (dq.size() == 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (dq.size() == 0 || gq.size() == 0) begin
            check("job_no_done", 0, 1);
            return;
        end
        check("job_gnt_count", gq.size(), 1);
        check("job_gnt_idx", gq[0].idx, r);
        check("job_done_idx", dq[0].idx, r);
        check("job_err", dq[0].e, ee);
        check("job_q_out", dq[0].q, eq);
        check("job_latency", dq[0].cyc - gq[0].cyc, el);
        if (b == 0) begin
            check("job_no_start", sq.size(), 0);
        end else begin
            check("job_start_count", sq.size(), 1);
            if (sq.size() > 0) begin
                check("job_start_delay", sq[0].cyc - gq[0].cyc, 2);
                check("job_div_a", sq[0].a, a);
                check("job_div_b", sq[0].b, b);
            end
        end
        mp = (r + 1) % NREQ;
    endtask

    task automatic run_multi(logic [NREQ-1:0] mask);
        int ra[NREQ];
        int rb[NREQ];
        int exp_order[$];
        int pend[NREQ];
        int n, cnt, pick;
        clear_q();
        last_order.delete();
        dv_lat = $urandom_range(0, 5);
        cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i]   = $urandom_range(0, 1023);
            rb[i]   = $urandom_range(1, 1023);
            pend[i] = mask[i] ? 1 : 0;
            cnt    += pend[i];
        end
        for (int j = 0; j < cnt; j++) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (pick < 0 && pend[(mp + k) % NREQ] != 0) pick = (mp + k) % NREQ;
            end
            exp_order.push_back(pick);
            pend[pick] = 0;
            mp = (pick + 1) % NREQ;
        end
        @(negedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            dividend_in[i*W +: W] = W'(ra[i]);
            divisor_in[i*W +: W]  = W'(rb[i]);
        end
        req = mask;
        n = 0;
        while (dq.size() < cnt && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("multi_done_count", dq.size(), cnt);
        check("multi_gnt_count", gq.size(), cnt);
        if (dq.size() < cnt || gq.size() < cnt) return;
        for (int j = 0; j < cnt; j++) begin
            last_order.push_back(gq[j].idx);
            check("multi_gnt_order", gq[j].idx, exp_order[j]);
            check("multi_done_idx", dq[j].idx, exp_order[j]);
            check("multi_err", dq[j].e, 0);
            check("multi_q", dq[j].q, ra[exp_order[j]] / rb[exp_order[j]]);
        end
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_q_out"}, q_out, 0);
        check({tag, "_div_a"}, div_a, 0);
        check({tag, "_div_b"}, div_b, 0);
    endtask

    typedef struct { int r; int a; int b; int lat; int eq; int ee; int el; } vec_t;
    vec_t tbl[8];

    initial begin
        int qm, r, a, b, lat, k, eq, ee, el, n;
        tbl[0] = '{2, 100,  7,  3,   14, 0,  7};
        tbl[1] = '{0,  55,  0,  3,   14, 1,  2};
        tbl[2] = '{1, 1023, 1,  0, 1023, 0,  4};
        tbl[3] = '{3,   5,  9, 63,    0, 0, 67};
        tbl[4] = '{1,  77,  3, -1,    0, 1, 67};
        tbl[5] = '{2, 999, 10, 64,    0, 1, 67};
        tbl[6] = '{0, 640, 32, 12,   20, 0, 16};
        tbl[7] = '{3,   0,  5,  1,    0, 0,  5};

        req = '0; dividend_in = '0; divisor_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mp = 0;

        // Round-robin with all four requesting from pointer 0.
        run_multi(4'b1111);
        check("rr_all_size", last_order.size(), 4);
        if (last_order.size() == 4) begin
            check("rr_all_0", last_order[0], 0);
            check("rr_all_1", last_order[1], 1);
            check("rr_all_2", last_order[2], 2);
            check("rr_all_3", last_order[3], 3);
        end
        run_job(0, 90, 9, 2, 10, 0, 6);
        run_multi(4'b1001);
        check("rr_1001_size", last_order.size(), 2);
        if (last_order.size() == 2) begin
            check("rr_1001_first", last_order[0], 3);
            check("rr_1001_second", last_order[1], 0);
        end

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].eq, tbl[i].ee, tbl[i].el);
        end

        qm = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, NREQ - 1);
            a = $urandom_range(0, 1023);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1023);
            k = $urandom_range(0, 9);
            lat = (k == 0) ? -1 : (k == 1) ? $urandom_range(60, 66) : $urandom_range(0, 20);
            if (b == 0) begin
                eq = qm; ee = 1; el = 2;
            end else if (lat >= 0 && lat <= TO) begin
                eq = a / b; ee = 0; el = lat + 4; qm = eq;
            end else begin
                eq = qm; ee = 1; el = TO + 4;
            end
            run_job(r, a, b, lat, eq, ee, el);
        end

        for (int i = 0; i < 8; i++) begin
            run_multi(NREQ'($urandom_range(1, 15)));
        end

        // Reset while a job sits in WAIT, then a stray valid.
        run_job(1, 300, 4, 2, 75, 0, 6);
        clear_q();
        dv_en = 1'b0;
        @(negedge clk); #1;
        dividend_in[2*W +: W] = W'(50);
        divisor_in[2*W +: W]  = W'(5);
        req[2] = 1'b1;
        n = 0;
        while (sq.size() == 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("midrst_started", sq.size(), 1);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        mp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req = '0;
        clear_q();
        @(negedge clk);
        div_q = W'(123);
        div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("stray_no_done", dq.size(), 0);
        check("stray_no_gnt", gq.size(), 0);
        check("stray_q_out", q_out, 0);
        dv_en = 1'b1;
        run_multi(4'b1010);
        check("post_rst_size", last_order.size(), 2);
        if (last_order.size() == 2) begin
            check("post_rst_first", last_order[0], 1);
            check("post_rst_second", last_order[1], 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
